// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU operation codes, decode field values and the sequencer state type.
// Shared by alu_ctrl_dec and alu_ctrl_seq.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_NOR     = 4'b0011;
  localparam logic [3:0] ALU_OR      = 4'b0100;
  localparam logic [3:0] ALU_SLT     = 4'b0101;
  localparam logic [3:0] ALU_MULT    = 4'b0110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational alu_op/funct to 4-bit ALU code decode table.
// MULT is decoded only when ALU_CTRL_MULT_EN is defined; otherwise funct 011000 is illegal.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] alu_op,
  input  logic [5:0]     funct,
  output logic [3:0]     code,
  output logic           illegal
);

  // Decode table; anything not listed falls through to the illegal code
  always_comb begin
    code    = ALU_ILLEGAL;
    illegal = 1'b1;
    case (alu_op)
      OPW'(OP_RTYPE): begin
        case (funct)
          FN_ADD:  begin code = ALU_ADD; illegal = 1'b0; end
          FN_SUB:  begin code = ALU_SUB; illegal = 1'b0; end
          FN_AND:  begin code = ALU_AND; illegal = 1'b0; end
          FN_NOR:  begin code = ALU_NOR; illegal = 1'b0; end
          FN_OR:   begin code = ALU_OR;  illegal = 1'b0; end
          FN_SLT:  begin code = ALU_SLT; illegal = 1'b0; end
`ifdef ALU_CTRL_MULT_EN
          FN_MULT: begin code = ALU_MULT; illegal = 1'b0; end
`endif
          default: begin code = ALU_ILLEGAL; illegal = 1'b1; end
        endcase
      end
      OPW'(OP_ADD): begin code = ALU_ADD; illegal = 1'b0; end
      OPW'(OP_SUB): begin code = ALU_SUB; illegal = 1'b0; end
      OPW'(OP_AND): begin code = ALU_AND; illegal = 1'b0; end
      OPW'(OP_OR):  begin code = ALU_OR;  illegal = 1'b0; end
      OPW'(OP_SLT): begin code = ALU_SLT; illegal = 1'b0; end
      default:      begin code = ALU_ILLEGAL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control with stall/flush handshake and a multi-cycle MULT sequence.
// Macro ALU_CTRL_MULT_EN enables MULT decode, the MUL/HOLD states and the cycle counter.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPW        = 3,
  parameter int CTRLW      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   alu_op,
  input  logic [5:0]       funct,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [CTRLW-1:0] alu_ctrl,
  output logic             illegal,
  output logic             busy
);

  logic [3:0]       dec_code_s;
  logic             dec_ill_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             out_valid_r, out_valid_s;
  logic [CTRLW-1:0] alu_ctrl_r, alu_ctrl_s;
  logic             illegal_r, illegal_s;

`ifdef ALU_CTRL_MULT_EN
  localparam int CNTW = $clog2(MUL_CYCLES);
  state_t           state_r, state_s;
  logic [CNTW-1:0]  cnt_r, cnt_s;

  assign in_ready_s = (state_r == IDLE) && !stall && !flush;
  assign busy       = (state_r != IDLE);
`else
  assign in_ready_s = !stall && !flush;
  assign busy       = 1'b0;
`endif

  assign accept_s  = in_valid && in_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign alu_ctrl  = alu_ctrl_r;
  assign illegal   = illegal_r;

  alu_ctrl_dec #(.OPW(OPW)) u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .code    (dec_code_s),
    .illegal (dec_ill_s)
  );

  // Next-state and next-output logic; flush outranks stall and acceptance
  always_comb begin
    out_valid_s = out_valid_r;
    alu_ctrl_s  = alu_ctrl_r;
    illegal_s   = illegal_r;
`ifdef ALU_CTRL_MULT_EN
    state_s     = state_r;
    cnt_s       = cnt_r;
`endif
    if (flush) begin
      out_valid_s = 1'b0;
      illegal_s   = 1'b0;
`ifdef ALU_CTRL_MULT_EN
      state_s     = IDLE;
      cnt_s       = {CNTW{1'b0}};
    end else if (state_r == MUL) begin
      // Result is registered on the edge that takes the counter to zero
      if (cnt_r != {CNTW{1'b0}}) begin
        cnt_s = cnt_r - CNTW'(1);
        if (cnt_r == CNTW'(1)) begin
          out_valid_s = 1'b1;
          alu_ctrl_s  = CTRLW'(ALU_MULT);
          illegal_s   = 1'b0;
        end else begin
          out_valid_s = 1'b0;
        end
      end else if (!stall) begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end else begin
        state_s     = HOLD;
      end
    end else if (state_r == HOLD) begin
      if (!stall) begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end else begin
        out_valid_s = out_valid_r;
      end
`endif
    end else if (accept_s) begin
`ifdef ALU_CTRL_MULT_EN
      if (dec_code_s == ALU_MULT) begin
        state_s     = MUL;
        cnt_s       = CNTW'(MUL_CYCLES - 1);
        out_valid_s = 1'b0;
        illegal_s   = 1'b0;
      end else
`endif
      begin
        out_valid_s = 1'b1;
        alu_ctrl_s  = CTRLW'(dec_code_s);
        illegal_s   = dec_ill_s;
      end
    end else if (!stall) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      alu_ctrl_r  <= {CTRLW{1'b0}};
      illegal_r   <= 1'b0;
`ifdef ALU_CTRL_MULT_EN
      state_r     <= IDLE;
      cnt_r       <= {CNTW{1'b0}};
`endif
    end else begin
      out_valid_r <= out_valid_s;
      alu_ctrl_r  <= alu_ctrl_s;
      illegal_r   <= illegal_s;
`ifdef ALU_CTRL_MULT_EN
      state_r     <= state_s;
      cnt_r       <= cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scenarios plus randomized traffic against a cycle-level reference model.
// Follows ALU_CTRL_MULT_EN the same way the design does.
module tb_alu_ctrl_seq;

  localparam int OPW   = 3;
  localparam int CTRLW = 4;
  localparam int MC    = 4;
`ifdef ALU_CTRL_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [OPW-1:0]   alu_op = '0;
  logic [5:0]       funct = '0;
  logic             in_ready, out_valid, illegal, busy;
  logic [CTRLW-1:0] alu_ctrl;

  int total = 0;
  int bad   = 0;

  // reference model: expected registered outputs and cycles spent in a MULT
  bit         m_valid, m_ill, m_busy;
  logic [3:0] m_ctrl;
  int         m_t;

  logic [5:0] fns [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100111,
                          6'b100101, 6'b101010, 6'b011000, 6'b111111};

  alu_ctrl_seq #(.OPW(OPW), .CTRLW(CTRLW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_ctrl(alu_ctrl), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // returns {is_mult, illegal, code} straight from the decode table
  function automatic logic [5:0] ref_decode(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: begin
        case (fn)
          6'b100000: return 6'b00_0000;
          6'b100010: return 6'b00_0001;
          6'b100100: return 6'b00_0010;
          6'b100111: return 6'b00_0011;
          6'b100101: return 6'b00_0100;
          6'b101010: return 6'b00_0101;
          6'b011000: return MULT_EN ? 6'b10_0110 : 6'b01_1111;
          default:   return 6'b01_1111;
        endcase
      end
      3'd1:    return 6'b00_0000;
      3'd2:    return 6'b00_0001;
      3'd3:    return 6'b00_0010;
      3'd4:    return 6'b00_0100;
      3'd5:    return 6'b00_0101;
      default: return 6'b01_1111;
    endcase
  endfunction

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    logic [5:0] d;
    bit acc;
    d   = ref_decode(alu_op, funct);
    acc = in_valid && !m_busy && !stall && !flush;
    if (flush) begin
      m_valid = 1'b0; m_ill = 1'b0; m_busy = 1'b0; m_t = 0;
    end else if (m_busy) begin
      if (m_t < MC) begin
        m_t = m_t + 1;
        if (m_t == MC) begin m_valid = 1'b1; m_ctrl = 4'd6; m_ill = 1'b0; end
      end else if (!stall) begin
        m_busy = 1'b0; m_t = 0; m_valid = 1'b0;
      end
    end else if (acc) begin
      if (d[5]) begin m_busy = 1'b1; m_t = 1; m_valid = 1'b0; end
      else begin m_valid = 1'b1; m_ctrl = d[3:0]; m_ill = d[4]; end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; alu_op = '0; funct = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (alu_ctrl !== 4'h0) begin bad++; $display("FAIL reset_alu_ctrl got=%h want=0", alu_ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    stall = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_stall got=%b want=0", in_ready); end
    stall = 1'b0;
  endtask

  task automatic test_rtype_sub();
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b000; funct = 6'b100010; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sub_in_ready got=%b want=1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sub_out_valid got=%b want=1", out_valid); end
    total++; if (alu_ctrl !== 4'b0001) begin bad++; $display("FAIL sub_alu_ctrl got=%b want=0001", alu_ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL sub_illegal got=%b want=0", illegal); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_consumed got=%b want=0", out_valid); end
  endtask

  task automatic test_stall_hold();
    in_valid = 1'b1; alu_op = 3'b011; funct = 6'b000000;
    @(negedge clk); in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("FAIL hold_alu_ctrl[%0d] got=%b want=0010", i, alu_ctrl); end
      @(negedge clk);
    end
    stall = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_last got=%b want=1", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [3] = '{3'b000, 3'b110, 3'b000};
    logic [5:0] fs  [3] = '{6'b111111, 6'b100000, 6'b011000};
    int n;
    n = MULT_EN ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; alu_op = ops[i]; funct = fs[i];
      @(negedge clk); in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ill_out_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (alu_ctrl !== 4'b1111) begin bad++; $display("FAIL ill_alu_ctrl[%0d] got=%b want=1111", i, alu_ctrl); end
      total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_flag[%0d] got=%b want=1", i, illegal); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
    in_valid = 1'b1; alu_op = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_op = 3'(i + 2);
      in_valid = (i < 4);
      total++; if (out_valid !== 1'b1 || alu_ctrl !== exp[i])
        begin bad++; $display("FAIL b2b[%0d] got=%b/%b want=1/%b", i, out_valid, alu_ctrl, exp[i]); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; alu_op = 3'b111;
    @(negedge clk);
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL flush_pre_illegal got=%b want=1", illegal); end
    stall = 1'b1; flush = 1'b1; alu_op = 3'b010; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    @(negedge clk); stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL flush_illegal got=%b want=0", illegal); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b want=0", out_valid); end
  endtask

  task automatic test_mult();
    in_valid = 1'b1; alu_op = 3'b000; funct = 6'b011000; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_in_ready0 got=%b want=1", in_ready); end
    @(negedge clk); alu_op = 3'b001;
    for (int k = 1; k <= MC; k++) begin
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy[%0d] got=%b want=1", k, busy); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_in_ready[%0d] got=%b want=0", k, in_ready); end
      total++; if (out_valid !== (k == MC)) begin bad++; $display("FAIL mul_out_valid[%0d] got=%b want=%b", k, out_valid, (k == MC)); end
      if (k == MC) begin
        total++; if (alu_ctrl !== 4'b0110) begin bad++; $display("FAIL mul_alu_ctrl got=%b want=0110", alu_ctrl); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL mul_done busy/ov/rdy got=%b%b%b want=001", busy, out_valid, in_ready); end
  endtask

  task automatic test_flush_mult();
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b000; funct = 6'b011000;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); flush = 1'b1; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fmul_busy_pre got=%b want=1", busy); end
    @(negedge clk); flush = 1'b0; #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL fmul_after busy/ov/rdy got=%b%b%b want=001", busy, out_valid, in_ready); end
    for (int k = 0; k < MC + 2; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fmul_late[%0d] got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; alu_op = 3'b010;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || alu_ctrl !== 4'h0)
      begin bad++; $display("FAIL areset_out got=%b/%h want=0/0", out_valid, alu_ctrl); end
    @(negedge clk); rst_n = 1'b1;
    if (MULT_EN) begin
      in_valid = 1'b1; alu_op = 3'b000; funct = 6'b011000;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0; #1;
      total++; if (busy !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0 || alu_ctrl !== 4'h0)
        begin bad++; $display("FAIL areset_mul busy/ov/ill/ctrl got=%b%b%b/%h want=000/0", busy, out_valid, illegal, alu_ctrl); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < MC + 2; k++) begin
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
          begin bad++; $display("FAIL areset_late[%0d] ov/busy got=%b%b want=00", k, out_valid, busy); end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    m_valid = 1'b0; m_ill = 1'b0; m_busy = 1'b0; m_t = 0; m_ctrl = 4'h0;
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      alu_op   = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(0, 7));
      funct    = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 7)] : 6'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      #1;
      total++; if (in_ready !== (!m_busy && !stall && !flush))
        begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b want=%b", i, in_ready, (!m_busy && !stall && !flush)); end
      @(negedge clk);
      model_step();
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b want=%b", i, out_valid, m_valid); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy[%0d] got=%b want=%b", i, busy, m_busy); end
      if (m_valid) begin
        total++; if (alu_ctrl !== CTRLW'(m_ctrl)) begin bad++; $display("FAIL rnd_alu_ctrl[%0d] got=%b want=%b", i, alu_ctrl, m_ctrl); end
        total++; if (illegal !== m_ill) begin bad++; $display("FAIL rnd_illegal[%0d] got=%b want=%b", i, illegal, m_ill); end
      end
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_stall_hold();
    test_illegal();
    test_back_to_back();
    test_flush();
    if (MULT_EN) begin
      test_mult();
      test_flush_mult();
    end
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
